rgmii_delay_ctrl: RTL



---
 rtl/rgmii_delay_pkg.sv | 23 ++
 rtl/rgmii_delay_ctrl_if.sv | 18 +
 rtl/rgmii_eye_window.sv | 49 ++++
 rtl/rgmii_delay_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_delay_pkg.sv
// Shared types and constants for the RGMII input-delay controller.
// Scan states exist only when RGMII_EYE_SCAN_EN is defined.
package rgmii_delay_pkg;

  localparam int DEF_TAP_W = 5;
  localparam int ERR_CNT_W = 8;

`ifdef RGMII_EYE_SCAN_EN
  typedef enum logic [2:0] {
    S_WAIT_RDY, S_LOAD, S_SETTLE, S_IDLE,
    S_SCAN_LOAD, S_SCAN_DWELL, S_SCAN_EVAL, S_SCAN_APPLY
  } state_t;
`else
  typedef enum logic [1:0] {
    S_WAIT_RDY, S_LOAD, S_SETTLE, S_IDLE
  } state_t;
`endif

  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/rgmii_delay_ctrl_if.sv
// Tap-load command channel: valid/ready handshake with lane select and tap value.
interface rgmii_delay_ctrl_if
  import rgmii_delay_pkg::*;
#(
  parameter int LANES = 5,
  parameter int TAP_W = DEF_TAP_W
);
  localparam int LANE_W = lane_w(LANES);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LANE_W-1:0] cmd_lane;
  logic              cmd_all;
  logic [TAP_W-1:0]  cmd_tap;

  modport master (output cmd_valid, cmd_lane, cmd_all, cmd_tap, input cmd_ready);
  modport slave  (input cmd_valid, cmd_lane, cmd_all, cmd_tap, output cmd_ready);
endinterface

// File: rtl/rgmii_eye_window.sv
// Tracks the longest contiguous run of passing taps during an eye scan and
// reports its centre (first run wins ties).
module rgmii_eye_window #(
  parameter int TAP_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [TAP_W-1:0] tap,
  input  logic             pass,
  output logic [TAP_W-1:0] best_tap,
  output logic             any_pass
);
  logic [TAP_W-1:0] cur_start, best_start, run_start;
  logic [TAP_W:0]   cur_len, best_len, run_len;

  assign run_start = (cur_len == '0) ? tap : cur_start;
  assign run_len   = cur_len + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (valid) begin
      if (pass) begin
        cur_start <= run_start;
        cur_len   <= run_len;
        // strict compare keeps the earliest run on equal length
        if (run_len > best_len) begin
          best_start <= run_start;
          best_len   <= run_len;
        end
      end else begin
        cur_len <= '0;
      end
    end
  end

  assign any_pass = (best_len != '0);
  assign best_tap = best_start + TAP_W'((best_len - 1'b1) >> 1);
endmodule

// File: rtl/rgmii_delay_ctrl.sv
// IDELAYE2 tap controller: reloads taps after IDELAYCTRL ready, applies commanded
// taps, and with RGMII_EYE_SCAN_EN defined sweeps all taps to centre the RX eye.
module rgmii_delay_ctrl
  import rgmii_delay_pkg::*;
#(
  parameter int LANES         = 5,
  parameter int TAP_W         = DEF_TAP_W,
  parameter int INIT_TAP      = 25,
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 1024
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     idelay_rdy,
  rgmii_delay_ctrl_if.slave        bus,
  output logic [LANES-1:0]         idelay_ld,
  output logic [LANES*TAP_W-1:0]   idelay_cntvalue,
  output logic [LANES*TAP_W-1:0]   tap_out,
`ifdef RGMII_EYE_SCAN_EN
  input  logic                     scan_start,
  input  logic                     err_pulse,
  output logic                     scan_done,
  output logic                     scan_fail,
  output logic [TAP_W-1:0]         scan_best_tap,
`endif
  output logic                     busy
);
  localparam int MAXC  = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef logic [LANES-1:0][TAP_W-1:0] taps_t;
  localparam taps_t TAPS_INIT = {LANES{TAP_W'(INIT_TAP)}};

  state_t           state;
  logic             rdy_meta, rdy_sync;
  taps_t            taps, cmd_taps;
  logic [LANES-1:0] ld, cmd_mask;
  logic [CNT_W-1:0] cnt;
  logic             ready_q, busy_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
    end else begin
      rdy_meta <= idelay_rdy;
      rdy_sync <= rdy_meta;
    end
  end

  // out-of-range lane without broadcast yields an empty mask: command is dropped
  always_comb begin
    cmd_mask = '0;
    if (bus.cmd_all)
      cmd_mask = '1;
    else if (int'(bus.cmd_lane) < LANES)
      cmd_mask[bus.cmd_lane] = 1'b1;
    for (int n = 0; n < LANES; n++)
      cmd_taps[n] = cmd_mask[n] ? bus.cmd_tap : taps[n];
  end

`ifdef RGMII_EYE_SCAN_EN
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [TAP_W-1:0]     scan_tap, next_tap, win_best, best_q;
  logic [ERR_CNT_W-1:0] err_cnt;
  taps_t                saved_taps;
  logic                 sweeping, applying, no_pass_q, done_q, fail_q;
  logic                 scan_go, win_any;

  assign next_tap = scan_tap + 1'b1;
  assign scan_go  = (state == S_IDLE) && !bus.cmd_valid && scan_start;

  rgmii_eye_window #(.TAP_W(TAP_W)) u_window (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (scan_go),
    .valid    (state == S_SCAN_EVAL),
    .tap      (scan_tap),
    .pass     (err_cnt == '0),
    .best_tap (win_best),
    .any_pass (win_any)
  );

  assign scan_done     = done_q;
  assign scan_fail     = fail_q;
  assign scan_best_tap = best_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_WAIT_RDY;
      taps    <= TAPS_INIT;
      ld      <= '0;
      cnt     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
`ifdef RGMII_EYE_SCAN_EN
      scan_tap   <= '0;
      err_cnt    <= '0;
      saved_taps <= TAPS_INIT;
      sweeping   <= 1'b0;
      applying   <= 1'b0;
      no_pass_q  <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      best_q     <= '0;
`endif
    end else begin
      ld <= '0;
`ifdef RGMII_EYE_SCAN_EN
      done_q <= 1'b0;
`endif
      if (state != S_WAIT_RDY && !rdy_sync) begin
        state   <= S_WAIT_RDY;
        ready_q <= 1'b0;
        busy_q  <= 1'b1;
`ifdef RGMII_EYE_SCAN_EN
        sweeping <= 1'b0;
        applying <= 1'b0;
`endif
      end else begin
        case (state)
          S_WAIT_RDY: if (rdy_sync) begin
            state <= S_LOAD;
            ld    <= '1;
          end
          S_LOAD: begin
            state <= S_SETTLE;
            cnt   <= '0;
          end
          S_SETTLE: if (cnt == SETTLE_LAST) begin
`ifdef RGMII_EYE_SCAN_EN
            if (sweeping) begin
              state   <= S_SCAN_DWELL;
              cnt     <= '0;
              err_cnt <= '0;
            end else
`endif
            begin
              state   <= S_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
`ifdef RGMII_EYE_SCAN_EN
              if (applying) begin
                done_q   <= 1'b1;
                fail_q   <= no_pass_q;
                applying <= 1'b0;
              end
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
          S_IDLE: begin
            if (bus.cmd_valid) begin
              if (cmd_mask != '0) begin
                taps    <= cmd_taps;
                ld      <= cmd_mask;
                state   <= S_LOAD;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
            end
`ifdef RGMII_EYE_SCAN_EN
            else if (scan_start) begin
              saved_taps <= taps;
              taps       <= '0;
              ld         <= '1;
              scan_tap   <= '0;
              sweeping   <= 1'b1;
              fail_q     <= 1'b0;
              state      <= S_SCAN_LOAD;
              ready_q    <= 1'b0;
              busy_q     <= 1'b1;
            end
`endif
          end
`ifdef RGMII_EYE_SCAN_EN
          S_SCAN_LOAD: begin
            state <= S_SETTLE;
            cnt   <= '0;
          end
          S_SCAN_DWELL: begin
            if (err_pulse && err_cnt != '1)
              err_cnt <= err_cnt + 1'b1;
            if (cnt == DWELL_LAST)
              state <= S_SCAN_EVAL;
            else
              cnt <= cnt + 1'b1;
          end
          S_SCAN_EVAL: begin
            if (scan_tap == '1) begin
              state    <= S_SCAN_APPLY;
              sweeping <= 1'b0;
            end else begin
              scan_tap <= next_tap;
              taps     <= {LANES{next_tap}};
              ld       <= '1;
              state    <= S_SCAN_LOAD;
            end
          end
          // window tracker has seen the last tap by now
          S_SCAN_APPLY: begin
            state     <= S_LOAD;
            ld        <= '1;
            applying  <= 1'b1;
            no_pass_q <= !win_any;
            if (win_any) begin
              taps   <= {LANES{win_best}};
              best_q <= win_best;
            end else begin
              taps <= saved_taps;
            end
          end
`endif
          default: state <= S_WAIT_RDY;
        endcase
      end
    end
  end

  assign idelay_ld       = ld;
  assign idelay_cntvalue = taps;
  assign tap_out         = taps;
  assign busy            = busy_q;
  assign bus.cmd_ready   = ready_q;
endmodule
